// File: rtl/ysyx_23060332_idu_stage.sv
// ysyx_23060332_idu_stage: RISC-V decode stage with registered operand/control outputs
// and a RUN/HALT machine that stops fetch after an illegal instruction or ebreak.
module ysyx_23060332_idu_stage #(
  parameter int XLEN = 32,
  parameter bit RV64 = (XLEN == 64)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [4:0]      raddr1,
  output logic [4:0]      raddr2,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] op1_jump,
  output logic [XLEN-1:0] op2_jump,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rd_wen,
  output logic [4:0]      rd_addr,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] pc_o,
  output logic            illegal,
  output logic            trap
);
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [31:0] EBREAK    = 32'h0010_0073;

  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] op1_jump;
    logic [XLEN-1:0] op2_jump;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [4:0]      rd_addr;
    logic            rd_wen;
    logic            illegal;
    logic            trap;
  } dec_t;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, four;
  logic            wen, fire;
  dec_t            dec, dec_d, dec_q;
  state_t          state_d, state_q;
  logic            out_valid_d, out_valid_q;

  assign opc   = inst_i[6:0];
  assign f3    = inst_i[14:12];
  assign rd    = inst_i[11:7];
  assign four  = XLEN'(4);
  assign imm_i = {{(XLEN-11){inst_i[31]}}, inst_i[30:20]};
  assign imm_s = {{(XLEN-11){inst_i[31]}}, inst_i[30:25], inst_i[11:7]};
  assign imm_b = {{(XLEN-12){inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u = {{(XLEN-31){inst_i[31]}}, inst_i[30:12], 12'b0};
  assign imm_j = {{(XLEN-20){inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  assign raddr1 = (opc == OPC_OP || opc == OPC_OP_IMM || opc == OPC_LOAD || opc == OPC_STORE ||
                   opc == OPC_BRANCH || opc == OPC_JALR) ? inst_i[19:15] : 5'd0;
  assign raddr2 = (opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH) ? inst_i[24:20] : 5'd0;

  always_comb begin
    dec          = '0;
    wen          = 1'b0;
    dec.rs1_data = rdata1;
    dec.rs2_data = rdata2;
    dec.inst     = inst_i;
    dec.pc       = pc_i;
    case (opc)
      OPC_OP:     begin dec.op1 = rdata1; dec.op2 = rdata2; wen = 1'b1; end
      OPC_OP_IMM: begin dec.op1 = rdata1; dec.op2 = imm_i; wen = 1'b1; end
      OPC_LOAD: begin
        dec.op1     = rdata1;
        dec.op2     = imm_i;
        wen         = 1'b1;
        dec.illegal = RV64 ? (f3 == 3'd7) : (f3 == 3'd3 || f3 >= 3'd6);
      end
      OPC_STORE: begin
        dec.op1     = rdata1;
        dec.op2     = imm_s;
        dec.illegal = f3 > (RV64 ? 3'd3 : 3'd2);
      end
      OPC_BRANCH: begin
        dec.op1      = rdata1;
        dec.op2      = rdata2;
        dec.op1_jump = pc_i;
        dec.op2_jump = imm_b;
        dec.illegal  = f3[2:1] == 2'b01;
      end
      OPC_JAL: begin
        dec.op1      = pc_i;
        dec.op2      = four;
        dec.op1_jump = pc_i;
        dec.op2_jump = imm_j;
        wen          = 1'b1;
      end
      OPC_JALR: begin
        dec.op1      = pc_i;
        dec.op2      = four;
        dec.op1_jump = rdata1;
        dec.op2_jump = imm_i;
        wen          = 1'b1;
      end
      OPC_LUI:    begin dec.op1 = imm_u; wen = 1'b1; end
      OPC_AUIPC:  begin dec.op1 = pc_i; dec.op2 = imm_u; wen = 1'b1; end
      OPC_SYSTEM: begin dec.trap = inst_i == EBREAK; dec.illegal = inst_i != EBREAK; end
      default:    dec.illegal = 1'b1;
    endcase
    dec.rd_wen  = wen && rd != 5'd0;
    dec.rd_addr = dec.rd_wen ? rd : 5'd0;
  end

  // rst_n gates in_ready so fetch sees no acceptance while reset is held
  assign in_ready = rst_n && state_q == RUN && (!out_valid_q || out_ready);
  assign fire     = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    dec_d       = dec_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (fire) begin
      out_valid_d = 1'b1;
      dec_d       = dec;
      state_d     = (dec.illegal || dec.trap) ? HALT : state_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      out_valid_q <= 1'b0;
      dec_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      dec_q       <= dec_d;
    end
  end

  assign out_valid = out_valid_q;
  assign op1       = dec_q.op1;
  assign op2       = dec_q.op2;
  assign op1_jump  = dec_q.op1_jump;
  assign op2_jump  = dec_q.op2_jump;
  assign rs1_data  = dec_q.rs1_data;
  assign rs2_data  = dec_q.rs2_data;
  assign rd_wen    = dec_q.rd_wen;
  assign rd_addr   = dec_q.rd_addr;
  assign inst_o    = dec_q.inst;
  assign pc_o      = dec_q.pc;
  assign illegal   = dec_q.illegal;
  assign trap      = dec_q.trap;
endmodule

// File: tb/tb_ysyx_23060332_idu_stage.sv
// tb_ysyx_23060332_idu_stage: directed checks of the decode stage, 32-bit instance
// plus a 64-bit instance for the RV64 immediate and load encodings.
module tb_ysyx_23060332_idu_stage;
  logic        clk, rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] inst, pc, rdata1, rdata2;
  logic [4:0]  raddr1, raddr2, rd_addr;
  logic [31:0] op1, op2, op1_jump, op2_jump, rs1_data, rs2_data, inst_o, pc_o;
  logic        rd_wen, illegal, trap;

  logic        in_valid_w, in_ready_w, flush_w, out_valid_w, out_ready_w;
  logic [31:0] inst_w, inst_o_w;
  logic [63:0] pc_w, rdata1_w, rdata2_w, pc_o_w;
  logic [4:0]  raddr1_w, raddr2_w, rd_addr_w;
  logic [63:0] op1_w, op2_w, op1_jump_w, op2_jump_w, rs1_data_w, rs2_data_w;
  logic        rd_wen_w, illegal_w, trap_w;

  int errors = 0;
  int checks = 0;

  ysyx_23060332_idu_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .inst_i(inst), .pc_i(pc),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .op1(op1), .op2(op2), .op1_jump(op1_jump),
    .op2_jump(op2_jump), .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_wen(rd_wen),
    .rd_addr(rd_addr), .inst_o(inst_o), .pc_o(pc_o), .illegal(illegal), .trap(trap)
  );

  ysyx_23060332_idu_stage #(.XLEN(64)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w), .inst_i(inst_w),
    .pc_i(pc_w), .raddr1(raddr1_w), .raddr2(raddr2_w), .rdata1(rdata1_w), .rdata2(rdata2_w),
    .flush(flush_w), .out_valid(out_valid_w), .out_ready(out_ready_w), .op1(op1_w), .op2(op2_w),
    .op1_jump(op1_jump_w), .op2_jump(op2_jump_w), .rs1_data(rs1_data_w), .rs2_data(rs2_data_w),
    .rd_wen(rd_wen_w), .rd_addr(rd_addr_w), .inst_o(inst_o_w), .pc_o(pc_o_w),
    .illegal(illegal_w), .trap(trap_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 0; flush = 0; out_ready = 1; inst = 0; pc = 0; rdata1 = 0; rdata2 = 0;
    in_valid_w = 0; flush_w = 0; out_ready_w = 1; inst_w = 0; pc_w = 0; rdata1_w = 0; rdata2_w = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rd_wen", rd_wen, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_trap", trap, 0);
    chk("rst_op1", op1, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("first_in_ready", in_ready, 1);

    // addi x1,x2,-1 ; wide: lui x5,0x80000
    in_valid = 1; inst = 32'hFFF10093; pc = 32'h100; rdata1 = 5; rdata2 = 7;
    in_valid_w = 1; inst_w = 32'h800002B7;
    #1;
    chk("addi_raddr1", raddr1, 2);
    chk("addi_raddr2", raddr2, 0);
    tick();
    chk("addi_out_valid", out_valid, 1);
    chk("addi_op1", op1, 5);
    chk("addi_op2", op2, 32'hFFFFFFFF);
    chk("addi_rd_wen", rd_wen, 1);
    chk("addi_rd_addr", rd_addr, 1);
    chk("addi_rs2_data", rs2_data, 7);
    chk("addi_op1_jump", op1_jump, 0);
    chk("lui64_op1", op1_w, 64'hFFFFFFFF80000000);
    chk("lui64_rd_addr", rd_addr_w, 5);

    // jal x1,+8 ; wide: ld x5,0(x1)
    inst = 32'h008000EF; pc = 32'h80000000;
    inst_w = 32'h0000B283; rdata1_w = 64'h123456789ABCDEF0;
    #1 chk("jal_raddr1", raddr1, 0);
    tick();
    chk("jal_op1", op1, 32'h80000000);
    chk("jal_op2", op2, 4);
    chk("jal_op1_jump", op1_jump, 32'h80000000);
    chk("jal_op2_jump", op2_jump, 8);
    chk("jal_rd_wen", rd_wen, 1);
    chk("ld64_illegal", illegal_w, 0);
    chk("ld64_op1", op1_w, 64'h123456789ABCDEF0);
    chk("ld64_rd_wen", rd_wen_w, 1);
    in_valid_w = 0;

    // add x3,x1,x2 then stall three cycles
    inst = 32'h002081B3; rdata1 = 10; rdata2 = 20; pc = 32'h104;
    tick();
    chk("add_op2", op2, 20);
    out_ready = 0; inst = 32'h00000013; rdata1 = 99; rdata2 = 0;
    #1 chk("stall_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_out_valid", out_valid, 1);
      chk("stall_op1", op1, 10);
      chk("stall_rd_addr", rd_addr, 3);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1;
    #1 chk("release_in_ready", in_ready, 1);
    tick();
    chk("nop_op1", op1, 99);
    chk("nop_rd_wen", rd_wen, 0);
    chk("nop_inst_o", inst_o, 32'h00000013);
    in_valid = 0;
    tick();
    chk("drain_out_valid", out_valid, 0);

    // beq x1,x2,+16 ; sw x2,-4(x1) ; lui x5,0x80000
    in_valid = 1; inst = 32'h00208863; pc = 32'h200; rdata1 = 3; rdata2 = 4;
    #1;
    chk("beq_raddr1", raddr1, 1);
    chk("beq_raddr2", raddr2, 2);
    tick();
    chk("beq_op1", op1, 3);
    chk("beq_op2", op2, 4);
    chk("beq_op1_jump", op1_jump, 32'h200);
    chk("beq_op2_jump", op2_jump, 16);
    chk("beq_rd_wen", rd_wen, 0);
    chk("beq_rd_addr", rd_addr, 0);
    inst = 32'hFE20AE23; rdata1 = 32'h1000; rdata2 = 32'h55;
    tick();
    chk("sw_op1", op1, 32'h1000);
    chk("sw_op2", op2, 32'hFFFFFFFC);
    chk("sw_rs2_data", rs2_data, 32'h55);
    chk("sw_op1_jump", op1_jump, 0);
    chk("sw_rd_wen", rd_wen, 0);
    inst = 32'h800002B7;
    tick();
    chk("lui32_op1", op1, 32'h80000000);
    chk("lui32_op2", op2, 0);
    chk("lui32_rd_addr", rd_addr, 5);
    in_valid = 0;
    tick();

    // flush beats both the held output and an offered illegal opcode
    in_valid = 1; inst = 32'hFFF10093; rdata1 = 5;
    tick();
    chk("pre_flush_out_valid", out_valid, 1);
    flush = 1; inst = 32'h0000007F;
    tick();
    chk("flush_out_valid", out_valid, 0);
    chk("flush_no_halt", in_ready, 1);
    flush = 0;
    tick();
    chk("opc7f_out_valid", out_valid, 1);
    chk("opc7f_illegal", illegal, 1);
    chk("opc7f_trap", trap, 0);
    chk("opc7f_halt", in_ready, 0);
    in_valid = 0;
    tick();
    chk("halt_drain_out_valid", out_valid, 0);
    chk("halt_in_ready", in_ready, 0);
    flush = 1;
    tick();
    chk("flush_keeps_halt", in_ready, 0);
    flush = 0;
    reset_pulse();

    // RV64-only ld on 32-bit is illegal; reset drops the held result at once
    out_ready = 0; in_valid = 1; inst = 32'h0000B003;
    tick();
    chk("ld32_illegal", illegal, 1);
    chk("ld32_out_valid", out_valid, 1);
    in_valid = 0; rst_n = 0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_illegal", illegal, 0);
    chk("async_inst_o", inst_o, 0);
    tick();
    rst_n = 1; out_ready = 1;
    #1 chk("ld32_rst_in_ready", in_ready, 1);

    // ebreak halts fetch after draining
    in_valid = 1; inst = 32'h00100073; pc = 32'h300;
    tick();
    chk("ebreak_trap", trap, 1);
    chk("ebreak_illegal", illegal, 0);
    chk("ebreak_out_valid", out_valid, 1);
    chk("ebreak_pc_o", pc_o, 32'h300);
    chk("ebreak_in_ready", in_ready, 0);
    inst = 32'h00000013;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt_hold_in_ready", in_ready, 0);
      chk("halt_hold_out_valid", out_valid, 0);
    end
    in_valid = 0;
    reset_pulse();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
